// File: rtl/line_prefetch_if.sv
// Read-port bundle between the line prefetcher and the DDR read controller.
// One request outstanding at a time; memData carries ten 3-bit pixels.
interface line_prefetch_if;
  logic        memReq;
  logic [23:0] memAddr;
  logic        memAck;
  logic        memValid;
  logic [31:0] memData;

  modport master (
    output memReq,
    output memAddr,
    input  memAck,
    input  memValid,
    input  memData
  );

  modport slave (
    input  memReq,
    input  memAddr,
    output memAck,
    output memValid,
    output memData
  );
endinterface

// File: rtl/line_prefetch.sv
// Double-buffered VGA line prefetcher: while one line buffer is displayed, the
// next frame line is fetched word by word from DDR into the other buffer.
module line_prefetch #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int          LINES     = 480,
  parameter int          WORDS     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lineStart,
  input  logic [8:0]             row,
  input  logic [9:0]             column,
  input  logic                   displayActive,
  line_prefetch_if.master        mem,
  output logic [2:0]             color,
  output logic                   underrun
);

  localparam int             WW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0]  W_LAST    = WW'(WORDS - 1);
  localparam logic [8:0]     LINE_LAST = 9'(LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_w;
  logic [WW-1:0] w_w_nxt;
  logic [8:0]    r_line;
  logic [8:0]    w_line_nxt;
  logic [8:0]    w_row_next;
  logic          r_disp;      // 0: buffer A is on screen, 1: buffer B
  logic          w_fill;
  logic [1:0]    r_valid;
  logic [1:0]    w_valid_nxt;
  logic          r_req;
  logic [23:0]   r_addr;
  logic [23:0]   w_addr_nxt;
  logic [2:0]    r_color;
  logic [2:0]    w_color_nxt;
  logic          r_underrun;
  logic          w_swap;
  logic          w_done;
  logic          w_wr;
  logic          w_underrun_set;
  logic [29:0]   r_buf_a [WORDS];
  logic [29:0]   r_buf_b [WORDS];
  logic [9:0]    w_word_idx;
  logic [9:0]    w_pix;
  logic [4:0]    w_shift;
  logic [29:0]   w_word;
  logic          w_unused_bits;

  assign w_fill        = ~r_disp;
  assign w_unused_bits = ^mem.memData[31:30];

  // Line to fetch after a lineStart: the one following the displayed row.
  always_comb begin
    w_row_next = 9'd0;
    if (row >= LINE_LAST) begin
      w_row_next = 9'd0;
    end else begin
      w_row_next = row + 9'd1;
    end
  end

  // Fetch FSM: completion is evaluated before an abort, so a final word that
  // lands together with lineStart still counts as a finished line.
  always_comb begin
    w_state_nxt    = r_state;
    w_w_nxt        = r_w;
    w_swap         = 1'b0;
    w_done         = 1'b0;
    w_wr           = 1'b0;
    w_underrun_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lineStart) begin
          w_swap      = 1'b1;
          w_w_nxt     = '0;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (lineStart) begin
          w_underrun_set = 1'b1;
          w_swap         = 1'b1;
          w_w_nxt        = '0;
          w_state_nxt    = mem.memAck ? S_DRAIN : S_REQ;
        end else if (mem.memAck) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem.memValid) begin
          w_wr = 1'b1;
          if (r_w == W_LAST) begin
            w_done = 1'b1;
            if (lineStart) begin
              w_swap      = 1'b1;
              w_w_nxt     = '0;
              w_state_nxt = S_REQ;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (lineStart) begin
            w_underrun_set = 1'b1;
            w_swap         = 1'b1;
            w_w_nxt        = '0;
            w_state_nxt    = S_REQ;
          end else begin
            w_w_nxt     = r_w + WW'(1);
            w_state_nxt = S_REQ;
          end
        end else if (lineStart) begin
          w_underrun_set = 1'b1;
          w_swap         = 1'b1;
          w_w_nxt        = '0;
          w_state_nxt    = S_DRAIN;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (lineStart) begin
          w_underrun_set = 1'b1;
          w_swap         = 1'b1;
          w_w_nxt        = '0;
          w_state_nxt    = mem.memValid ? S_REQ : S_DRAIN;
        end else if (mem.memValid) begin
          w_w_nxt     = '0;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next request address and the per-buffer valid flags.
  always_comb begin
    w_line_nxt  = w_swap ? w_row_next : r_line;
    w_addr_nxt  = BASE_ADDR + (24'(w_line_nxt) * 24'(WORDS)) + 24'(w_w_nxt);
    w_valid_nxt = r_valid;
    if (w_done) begin
      w_valid_nxt[w_fill] = 1'b1;
    end else begin
      w_valid_nxt[w_fill] = r_valid[w_fill];
    end
    if (w_swap) begin
      w_valid_nxt[r_disp] = 1'b0;
    end else begin
      w_valid_nxt[r_disp] = r_valid[r_disp];
    end
  end

  // Pixel lookup in the on-screen buffer.
  always_comb begin
    w_word_idx  = column / 10'd10;
    w_pix       = column % 10'd10;
    w_shift     = 5'(w_pix) * 5'd3;
    w_word      = 30'd0;
    w_color_nxt = 3'b000;
    if (displayActive && r_valid[r_disp] && (w_word_idx < 10'(WORDS))) begin
      w_word      = r_disp ? r_buf_b[w_word_idx[WW-1:0]] : r_buf_a[w_word_idx[WW-1:0]];
      w_color_nxt = w_word[w_shift +: 3];
    end else begin
      w_color_nxt = 3'b000;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_line     <= 9'd0;
      r_disp     <= 1'b0;
      r_valid    <= 2'b00;
      r_req      <= 1'b0;
      r_addr     <= 24'd0;
      r_color    <= 3'b000;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_w        <= w_w_nxt;
      r_line     <= w_line_nxt;
      r_valid    <= w_valid_nxt;
      r_req      <= (w_state_nxt == S_REQ);
      r_color    <= w_color_nxt;
      r_underrun <= r_underrun | w_underrun_set;
      if (w_swap) begin
        r_disp <= ~r_disp;
      end
      if (w_state_nxt == S_REQ) begin
        r_addr <= w_addr_nxt;
      end
    end
  end

  // Buffer storage has no reset; the valid flags gate its use.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      if (w_fill) begin
        r_buf_b[r_w] <= mem.memData[29:0];
      end else begin
        r_buf_a[r_w] <= mem.memData[29:0];
      end
    end
  end

  assign mem.memReq  = r_req;
  assign mem.memAddr = r_addr;
  assign color       = r_color;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_line_prefetch.sv
// Bench for line_prefetch: DDR responder, a line-level display model checked
// every cycle, and directed scenarios with hand-computed pixel values.
module tb_line_prefetch;
  localparam int          LINES = 480;
  localparam int          WORDS = 64;
  localparam logic [23:0] BASE  = 24'h000000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lineStart = 1'b0;
  logic [8:0] row = 9'd0;
  logic [9:0] column = 10'd0;
  logic       displayActive = 1'b0;
  logic [2:0] color;
  logic       underrun;

  line_prefetch_if mem ();

  line_prefetch #(.BASE_ADDR(BASE), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .lineStart(lineStart), .row(row), .column(column),
    .displayActive(displayActive), .mem(mem), .color(color), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents; address 65 (line 1, word 1) holds a hand-chosen word.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    logic [31:0] v;
    if (a == 24'd65) begin
      v = 32'hC000_01C0;
    end else begin
      v = ({8'h00, a} * 32'h0001_2345) + 32'h0000_05A5;
      v[31:30] = 2'b11;
    end
    return v;
  endfunction

  function automatic logic [2:0] ref_color(input int line, input int col, input bit act);
    logic [31:0] wd;
    if (!act || line < 0) return 3'b000;
    wd = mem_word(24'(BASE + line * WORDS + col / 10));
    return wd[3 * (col % 10) +: 3];
  endfunction

  // Model of what the screen must show: a line is displayable only if all its
  // words came back, in order, between the two lineStarts bracketing its fetch.
  int          disp_line = -1;
  int          fill_line = -1;
  int          fill_words = 0;
  int          acc_in_fetch = 0;
  bit          exp_underrun = 1'b0;
  logic [2:0]  exp_color = 3'b000;
  bit          model_on = 1'b0;
  bit          hold_chk = 1'b0;
  logic [23:0] prev_addr = 24'd0;
  logic [23:0] pend_addr[$];
  int          pend_cnt[$];
  logic [23:0] acc_log[$];
  logic [23:0] ret_addr = 24'd0;

  int ack_delay = 1;
  int data_lat  = 2;
  bit hold_ack  = 1'b0;
  int req_age   = 0;

  always @(negedge clk) begin
    if (model_on) begin
      check("color", {29'd0, color}, {29'd0, exp_color});
      check("underrun", {31'd0, underrun}, {31'd0, exp_underrun});
      if (hold_chk) begin
        check("req_held", {31'd0, mem.memReq}, 32'd1);
        check("addr_held", {8'd0, mem.memAddr}, {8'd0, prev_addr});
      end
    end
    if (!rst) begin
      exp_color    = 3'b000;
      exp_underrun = 1'b0;
      disp_line    = -1;
      fill_line    = -1;
      fill_words   = 0;
      acc_in_fetch = 0;
      hold_chk     = 1'b0;
      pend_addr.delete();
      pend_cnt.delete();
      model_on     = 1'b1;
    end else begin
      exp_color = ref_color(disp_line, int'(column), displayActive);
      hold_chk  = mem.memReq && !mem.memAck && !lineStart;
      prev_addr = mem.memAddr;
      if (mem.memReq && mem.memAck) begin
        check("fetch_addr", {8'd0, mem.memAddr}, 32'(BASE + fill_line * WORDS + acc_in_fetch));
        acc_in_fetch++;
        acc_log.push_back(mem.memAddr);
        pend_addr.push_back(mem.memAddr);
        pend_cnt.push_back(data_lat);
      end
      if (mem.memValid && fill_line >= 0 && fill_words < WORDS &&
          ret_addr == 24'(BASE + fill_line * WORDS + fill_words)) begin
        fill_words++;
      end
      if (lineStart) begin
        if (fill_line >= 0 && fill_words < WORDS) exp_underrun = 1'b1;
        disp_line    = (fill_line >= 0 && fill_words == WORDS) ? fill_line : -1;
        fill_line    = (int'(row) + 1) % LINES;
        fill_words   = 0;
        acc_in_fetch = 0;
      end
    end
  end

  // DDR responder: acks after ack_delay cycles of request, returns data data_lat later.
  initial begin
    mem.memAck   = 1'b0;
    mem.memValid = 1'b0;
    mem.memData  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem.memAck   = 1'b0;
      mem.memValid = 1'b0;
      mem.memData  = 32'd0;
      if (!rst) begin
        req_age = 0;
      end else begin
        if (mem.memReq) begin
          if (!hold_ack && req_age >= ack_delay) begin
            mem.memAck = 1'b1;
            req_age    = 0;
          end else begin
            req_age++;
          end
        end else begin
          req_age = 0;
        end
        if (pend_cnt.size() > 0) begin
          if (pend_cnt[0] > 0) pend_cnt[0] = pend_cnt[0] - 1;
          if (pend_cnt[0] == 0) begin
            ret_addr = pend_addr.pop_front();
            void'(pend_cnt.pop_front());
            mem.memValid = 1'b1;
            mem.memData  = mem_word(ret_addr);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_line(input int r);
    row       = 9'(r);
    lineStart = 1'b1;
    tick(1);
    lineStart = 1'b0;
  endtask

  task automatic wait_fetch(input string nm);
    int n = 0;
    while (fill_words < WORDS && n < 3000) begin
      tick(1);
      n++;
    end
    check(nm, 32'(fill_words), 32'(WORDS));
  endtask

  task automatic wait_acc(input string nm, input int k);
    int n = 0;
    while (acc_in_fetch < k && n < 3000) begin
      tick(1);
      n++;
    end
    check(nm, 32'(acc_in_fetch), 32'(k));
  endtask

  task automatic sweep(input int step);
    displayActive = 1'b1;
    for (int c = 0; c < 640; c += step) begin
      column = 10'(c);
      tick(1);
    end
  endtask

  initial begin
    bit found;
    int n;
    rst = 1'b0;
    tick(3);
    check("rst_req", {31'd0, mem.memReq}, 32'd0);
    check("rst_addr", {8'd0, mem.memAddr}, 32'd0);
    check("rst_color", {29'd0, color}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b1;
    displayActive = 1'b1;
    column = 10'd12;
    tick(3);

    // First line: fetch of line 1 into the fill buffer.
    acc_log.delete();
    pulse_line(0);
    wait_fetch("fetch_row0");
    check("row0_count", 32'(acc_log.size()), 32'd64);
    check("row0_first", (acc_log.size() > 0) ? {8'd0, acc_log[0]} : 32'hFFFF_FFFF, 32'd64);
    check("row0_last", (acc_log.size() > 63) ? {8'd0, acc_log[63]} : 32'hFFFF_FFFF, 32'd127);
    check("row0_underrun", {31'd0, underrun}, 32'd0);

    // Display line 1: word 1 = 0x1C0 -> pixel 2 (column 12) is 7, pixel 3 is 0.
    column = 10'd12;
    pulse_line(1);
    tick(1);
    check("pix_c12", {29'd0, color}, 32'd7);
    column = 10'd13;
    tick(1);
    check("pix_c13", {29'd0, color}, 32'd0);
    column = 10'd12;
    displayActive = 1'b0;
    tick(1);
    check("pix_blank", {29'd0, color}, 32'd0);
    sweep(7);
    wait_fetch("fetch_row1");

    // Last row wraps to line 0.
    acc_log.delete();
    pulse_line(479);
    wait_fetch("fetch_row479");
    check("wrap_first", (acc_log.size() > 0) ? {8'd0, acc_log[0]} : 32'hFFFF_FFFF, 32'd0);
    check("wrap_last", (acc_log.size() > 63) ? {8'd0, acc_log[63]} : 32'hFFFF_FFFF, 32'd63);
    pulse_line(0);
    sweep(11);
    wait_fetch("fetch_after_wrap");

    // Withheld ack: request and address must hold.
    hold_ack = 1'b1;
    acc_log.delete();
    pulse_line(5);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_req", {31'd0, mem.memReq}, 32'd1);
      check("hold_addr", {8'd0, mem.memAddr}, 32'd384);
    end
    hold_ack = 1'b0;
    wait_fetch("fetch_row5");
    check("hold_first", (acc_log.size() > 0) ? {8'd0, acc_log[0]} : 32'hFFFF_FFFF, 32'd384);

    // lineStart while waiting on word 20: underrun, drain, restart.
    data_lat = 4;
    pulse_line(10);
    wait_acc("acc_w20", 21);
    acc_log.delete();
    pulse_line(11);
    check("underrun_set", {31'd0, underrun}, 32'd1);
    displayActive = 1'b1;
    column = 10'd12;
    tick(2);
    check("partial_blank", {29'd0, color}, 32'd0);
    wait_fetch("fetch_after_drain");
    check("drain_first", (acc_log.size() > 0) ? {8'd0, acc_log[0]} : 32'hFFFF_FFFF, 32'd768);
    data_lat = 2;
    sweep(13);

    // Reset in the middle of a fetch.
    pulse_line(29);
    wait_acc("acc_before_rst", 5);
    rst = 1'b0;
    tick(2);
    check("mid_rst_req", {31'd0, mem.memReq}, 32'd0);
    check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    check("mid_rst_color", {29'd0, color}, 32'd0);
    rst = 1'b1;
    tick(2);

    // lineStart on the cycle of the final memValid counts as completion.
    displayActive = 1'b1;
    column = 10'd12;
    pulse_line(20);
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      @(posedge clk);
      #2;
      if (mem.memValid && fill_words == WORDS - 1) found = 1'b1;
      n++;
    end
    check("final_valid_seen", {31'd0, found}, 32'd1);
    row = 9'd21;
    lineStart = 1'b1;
    @(posedge clk);
    #1;
    lineStart = 1'b0;
    check("final_ls_underrun", {31'd0, underrun}, 32'd0);
    tick(1);
    check("line21_c12", {29'd0, color}, 32'd4);
    sweep(9);
    wait_fetch("fetch_row21");
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
    $fatal(1);
  end

endmodule
